timer_irq_unit: RTL and testbench
=================================

Name: timer_irq_unit

Overview:
- Parametrised multi-channel down-counting timer that generates the `int_timer` interrupt request for the pipelined interrupt-capable CPU top, replacing the hand-driven pulse.
- Each channel has a reload value, one-shot or periodic mode, a sticky pending flag and an interrupt enable.
- The CPU accesses the channels through a simple register write/read port.
- Per-channel and OR-combined interrupt lines feed the core's interrupt input.

Parameters:
- CH_NUM, 4, number of timer channels (1..16).
- CNT_W, 32, counter/reload width and data-bus width.
- PRE_DIV, 1, global prescaler: one count tick every PRE_DIV clocks (>=1).
- ADDR_W, $clog2(CH_NUM)+2, register address width. Derived; do not override.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  register write strobe, one cycle
- wr_addr  in  ADDR_W  {channel, reg[1:0]}
- wr_data  in  CNT_W  write data
- rd_addr  in  ADDR_W  {channel, reg[1:0]}
- rd_data  out  CNT_W  registered read data
- irq_ack  in  CH_NUM  per-channel pending clear, one-cycle pulse
- irq  out  CH_NUM  per-channel interrupt level = pending & irq_en
- int_timer  out  1  OR of irq, registered

Behaviour:
- Register map per channel:
  - reg 0 CTRL: bit0 en, bit1 mode (0 periodic, 1 one-shot), bit2 irq_en; other bits read 0.
  - reg 1 LOAD: reload value.
  - reg 2 COUNT: current value, read-only; writes ignored.
  - reg 3 STATUS: bit0 pending; writing 1 to bit0 clears it, writing 0 has no effect.
- Addresses with channel >= CH_NUM: reads return 0, writes are ignored.
- Reset: all CTRL, LOAD, COUNT and pending cleared; prescaler counter = 0; rd_data = 0; irq = 0; int_timer = 0.
- Prescaler:
  - Free-running 0..PRE_DIV-1 counter.
  - tick is asserted in the cycle it equals PRE_DIV-1.
  - With PRE_DIV=1, tick is asserted every cycle.
- Start:
  - A CTRL write that changes en 0->1 loads COUNT<=LOAD in that same clock edge.
  - No decrement occurs in the start cycle.
- Per channel, on tick with en=1:
  - COUNT != 0: COUNT <= COUNT-1.
  - COUNT == 0: pending <= 1. In periodic mode COUNT <= LOAD. In one-shot mode en <= 0 and COUNT stays 0.
  - Resulting period is LOAD+1 ticks. LOAD=0 in periodic mode sets pending on every tick.
- LOAD written while running takes effect at the next reload only; COUNT is not disturbed.
- CTRL write with en=0 stops the channel immediately; COUNT holds its value and pending is unchanged.
- Pending clear sources: irq_ack[i] or a STATUS write-1.
- If a pending set and a clear occur in the same cycle, set wins (the event is not lost).
- Pending is sticky regardless of irq_en. Setting irq_en later asserts irq if pending=1.
- irq is combinational from registered pending/irq_en.
- int_timer is registered: it asserts 1 cycle after irq.
- Latency: pending rises at the edge ending the tick cycle where COUNT==0; int_timer follows one clock later.
- rd_data <= selected register one clock after rd_addr. It updates every cycle (no read enable). Reading has no side effects.
- Reset asserted mid-count returns everything to reset values asynchronously; counting never resumes without a fresh en write.

Test Plan:
- Reset check: hold rst_n=0, toggle inputs -> rd_data, irq, int_timer all 0; after release, all reads return 0.
- Periodic mode, PRE_DIV=1, ch0:
  - Stimulus: LOAD=3, CTRL=0b101.
  - Required: pending first set 4 clocks after the CTRL write edge, then every 4 clocks.
  - irq[0] high from that edge; int_timer high one clock later.
- One-shot, ch2:
  - Stimulus: LOAD=5, CTRL=0b111.
  - Required: exactly one pending after 6 ticks; CTRL reads 0b110 and COUNT reads 0 afterwards.
  - After the ack, no further irq over 50 cycles.
- Clear race:
  - Stimulus: ch1 periodic with LOAD=0; pulse irq_ack[1] repeatedly, coinciding with ticks.
  - Required: pending remains 1 whenever a set coincides with a clear.
  - Required: a STATUS write of 0 leaves pending unchanged.
- PRE_DIV=4 build:
  - Stimulus: LOAD=2, periodic.
  - Required: period = 12 clocks.
  - A LOAD=1 write mid-count changes the period to 8 clocks only after the current reload.
- Masking and out-of-range:
  - Stimulus: irq_en=0 while the channel expires; then set irq_en=1.
  - Required: irq=0 while masked; irq=1 immediately after irq_en is set.
  - Required: writes/reads at channel index CH_NUM (CH_NUM=3 build) are ignored and return 0.

Source files
------------

// File: rtl/timer_irq_unit.sv
// Multi-channel down-counting timer with sticky per-channel pending flags.
// A register port gives access to the channels; the combined interrupt goes to the CPU as int_timer.
module timer_irq_unit #(
  parameter int CH_NUM  = 4,
  parameter int CNT_W   = 32,
  parameter int PRE_DIV = 1,
  parameter int ADDR_W  = $clog2(CH_NUM) + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  input  logic [CH_NUM-1:0] irq_ack,
  output logic [CH_NUM-1:0] irq,
  output logic              int_timer
);

  localparam int               PRE_W      = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(PRE_DIV - 1);
  localparam logic [1:0]       REG_CTRL   = 2'd0;
  localparam logic [1:0]       REG_LOAD   = 2'd1;
  localparam logic [1:0]       REG_COUNT  = 2'd2;
  localparam logic [1:0]       REG_STATUS = 2'd3;

  function automatic logic [CNT_W-1:0] reg_view(
    input logic [1:0]       sel,
    input logic             en,
    input logic             mode,
    input logic             irq_en,
    input logic             pend,
    input logic [CNT_W-1:0] load,
    input logic [CNT_W-1:0] count
  );
    case (sel)
      REG_CTRL:   reg_view = {{(CNT_W-3){1'b0}}, irq_en, mode, en};
      REG_LOAD:   reg_view = load;
      REG_COUNT:  reg_view = count;
      REG_STATUS: reg_view = {{(CNT_W-1){1'b0}}, pend};
      default:    reg_view = '0;
    endcase
  endfunction

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              tick_s;
  logic [ADDR_W-1:0] wr_ch_s, rd_ch_s;
  logic [1:0]        wr_reg_s, rd_reg_s;

  logic [CH_NUM-1:0] en_q, en_d, mode_q, mode_d, ie_q, ie_d, pend_q, pend_d;
  logic [CNT_W-1:0]  load_q [CH_NUM];
  logic [CNT_W-1:0]  load_d [CH_NUM];
  logic [CNT_W-1:0]  count_q [CH_NUM];
  logic [CNT_W-1:0]  count_d [CH_NUM];

  logic [CH_NUM-1:0] wr_hit_s, ctrl_wr_s, start_s, run_s, expire_s, clr_s;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic              int_timer_q, int_timer_d;

  // Channel index may be zero bits wide when CH_NUM=1, hence the shift.
  assign wr_ch_s  = wr_addr >> 2;
  assign rd_ch_s  = rd_addr >> 2;
  assign wr_reg_s = wr_addr[1:0];
  assign rd_reg_s = rd_addr[1:0];

  always_comb begin
    tick_s = (pre_q == PRE_LAST);
    if (tick_s) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // A CTRL write clearing en blocks the tick in the same cycle, so the channel stops at once.
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      wr_hit_s[i]  = wr_en && (wr_ch_s == ADDR_W'(i));
      ctrl_wr_s[i] = wr_hit_s[i] && (wr_reg_s == REG_CTRL);
      start_s[i]   = ctrl_wr_s[i] && wr_data[0] && !en_q[i];
      run_s[i]     = en_q[i] && !(ctrl_wr_s[i] && !wr_data[0]) && tick_s;
      expire_s[i]  = run_s[i] && (count_q[i] == '0);
      clr_s[i]     = irq_ack[i] || (wr_hit_s[i] && (wr_reg_s == REG_STATUS) && wr_data[0]);
    end
  end

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      mode_d[i] = ctrl_wr_s[i] ? wr_data[1] : mode_q[i];
      ie_d[i]   = ctrl_wr_s[i] ? wr_data[2] : ie_q[i];
      en_d[i]   = (expire_s[i] && mode_q[i]) ? 1'b0 : (ctrl_wr_s[i] ? wr_data[0] : en_q[i]);
      if (start_s[i]) begin
        count_d[i] = load_q[i];
      end else if (run_s[i] && !expire_s[i]) begin
        count_d[i] = count_q[i] - CNT_W'(1);
      end else if (expire_s[i] && !mode_q[i]) begin
        count_d[i] = load_q[i];
      end else begin
        count_d[i] = count_q[i];
      end
      if (wr_hit_s[i] && (wr_reg_s == REG_LOAD)) begin
        load_d[i] = wr_data;
      end else begin
        load_d[i] = load_q[i];
      end
      // Set beats a simultaneous clear so no expiry is lost.
      pend_d[i] = expire_s[i] | (pend_q[i] & ~clr_s[i]);
    end
  end

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      rd_data_d = rd_data_d | ({CNT_W{rd_ch_s == ADDR_W'(i)}} &
                  reg_view(rd_reg_s, en_q[i], mode_q[i], ie_q[i], pend_q[i], load_q[i], count_q[i]));
    end
  end

  always_comb begin
    irq         = pend_q & ie_q;
    int_timer_d = |irq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q       <= '0;
      en_q        <= '0;
      mode_q      <= '0;
      ie_q        <= '0;
      pend_q      <= '0;
      rd_data_q   <= '0;
      int_timer_q <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
        load_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      pre_q       <= pre_d;
      en_q        <= en_d;
      mode_q      <= mode_d;
      ie_q        <= ie_d;
      pend_q      <= pend_d;
      rd_data_q   <= rd_data_d;
      int_timer_q <= int_timer_d;
      for (int i = 0; i < CH_NUM; i++) begin
        load_q[i]  <= load_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign int_timer = int_timer_q;

endmodule

// File: tb/tb_timer_irq_unit.sv
// Scoreboard bench: two builds (4 ch / PRE_DIV=1 and 3 ch / PRE_DIV=4) share one stimulus stream
// and are compared every cycle against a behavioural model, plus directed period/race checks.
module tb_timer_irq_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr;
  logic [3:0]  irq_ack;
  logic [31:0] rd_data_a, rd_data_b;
  logic [3:0]  irq_a;
  logic [2:0]  irq_b;
  logic [3:0]  irq_b4;
  logic        int_timer_a, int_timer_b;

  always #5 clk = ~clk;
  assign irq_b4 = {1'b0, irq_b};

  timer_irq_unit #(.CH_NUM(4), .CNT_W(32), .PRE_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .irq_ack(irq_ack), .irq(irq_a), .int_timer(int_timer_a));

  timer_irq_unit #(.CH_NUM(3), .CNT_W(32), .PRE_DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .irq_ack(irq_ack[2:0]), .irq(irq_b), .int_timer(int_timer_b));

  typedef struct {
    logic [31:0] rd0, rd1;
    logic [3:0]  irq0, irq1;
    logic        it0, it1;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  bit   chk_on = 1'b0;

  // Behavioural model state, index [build][channel].
  int       nch [2] = '{4, 3};
  int       pdv [2] = '{1, 4};
  int       pre [2];
  bit       m_en [2][4];
  bit       m_md [2][4];
  bit       m_ie [2][4];
  bit       m_pd [2][4];
  bit [31:0] m_ld [2][4];
  bit [31:0] m_cn [2][4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pre[k] = 0;
      for (int c = 0; c < 4; c++) begin
        m_en[k][c] = 0; m_md[k][c] = 0; m_ie[k][c] = 0; m_pd[k][c] = 0;
        m_ld[k][c] = 0; m_cn[k][c] = 0;
      end
    end
  endtask

  task automatic model_cycle(input bit we, input bit [3:0] wa, input bit [31:0] wd,
                             input bit [3:0] ack, input bit [3:0] ra);
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      bit [31:0] rdv;
      bit        itv, tick;
      bit [3:0]  irqv;
      int        rc, wc;
      rc = int'(ra >> 2);
      wc = int'(wa >> 2);
      rdv = 32'd0;
      if (rc < nch[k]) begin
        case (ra[1:0])
          2'd0:    rdv = {29'd0, m_ie[k][rc], m_md[k][rc], m_en[k][rc]};
          2'd1:    rdv = m_ld[k][rc];
          2'd2:    rdv = m_cn[k][rc];
          default: rdv = {31'd0, m_pd[k][rc]};
        endcase
      end
      itv = 0;
      for (int c = 0; c < nch[k]; c++) itv = itv | (m_pd[k][c] & m_ie[k][c]);
      tick = (pre[k] == pdv[k] - 1);
      pre[k] = tick ? 0 : pre[k] + 1;
      for (int c = 0; c < nch[k]; c++) begin
        bit hit, counting, set, old_mode, clr;
        hit = we && (wc == c);
        old_mode = m_md[k][c];
        set = 0;
        if (hit && wa[1:0] == 2'd0) begin
          counting = m_en[k][c] && wd[0];
          if (wd[0] && !m_en[k][c]) m_cn[k][c] = m_ld[k][c];
          m_en[k][c] = wd[0];
          m_md[k][c] = wd[1];
          m_ie[k][c] = wd[2];
        end else begin
          counting = m_en[k][c];
        end
        if (tick && counting) begin
          if (m_cn[k][c] != 0) m_cn[k][c] = m_cn[k][c] - 1;
          else begin
            set = 1;
            if (old_mode) m_en[k][c] = 0;
            else m_cn[k][c] = m_ld[k][c];
          end
        end
        if (hit && wa[1:0] == 2'd1) m_ld[k][c] = wd;
        clr = ack[c] || (hit && wa[1:0] == 2'd3 && wd[0]);
        m_pd[k][c] = set || (m_pd[k][c] && !clr);
      end
      irqv = 4'd0;
      for (int c = 0; c < nch[k]; c++) irqv[c] = m_pd[k][c] & m_ie[k][c];
      if (k == 0) begin e.rd0 = rdv; e.irq0 = irqv; e.it0 = itv; end
      else        begin e.rd1 = rdv; e.irq1 = irqv; e.it1 = itv; end
    end
    expq.push_back(e);
  endtask

  // Monitor: pops one expected response per clock edge while checking is enabled.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (chk_on) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
      end else begin
        e = expq.pop_front();
        check("a_rd_data", rd_data_a, e.rd0);
        check("b_rd_data", rd_data_b, e.rd1);
        check("a_irq", {28'd0, irq_a}, {28'd0, e.irq0});
        check("b_irq", {29'd0, irq_b}, {29'd0, e.irq1[2:0]});
        check("a_int_timer", {31'd0, int_timer_a}, {31'd0, e.it0});
        check("b_int_timer", {31'd0, int_timer_b}, {31'd0, e.it1});
      end
    end
  end

  task automatic step(input bit we, input bit [3:0] wa, input bit [31:0] wd,
                      input bit [3:0] ack, input bit [3:0] ra);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; irq_ack = ack; rd_addr = ra;
    model_cycle(we, wa, wd, ack, ra);
    chk_on = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 32'd0, 4'd0, 4'($urandom_range(0, 15)));
  endtask

  task automatic wr(input bit [3:0] a, input bit [31:0] d);
    step(1'b1, a, d, 4'd0, 4'($urandom_range(0, 15)));
  endtask

  task automatic ack_step(input bit [3:0] v);
    step(1'b0, 4'd0, 32'd0, v, 4'($urandom_range(0, 15)));
  endtask

  function automatic bit irq_bit(input int k, input int ch);
    return (k == 0) ? irq_a[ch] : irq_b4[ch];
  endfunction

  task automatic wait_irq(input int k, input int ch, input int maxn, output int n);
    n = 0;
    do begin
      idle();
      n++;
    end while (!irq_bit(k, ch) && n < maxn);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_a"}, rd_data_a, 32'd0);
    check({tag, "_rd_b"}, rd_data_b, 32'd0);
    check({tag, "_irq_a"}, {28'd0, irq_a}, 32'd0);
    check({tag, "_irq_b"}, {29'd0, irq_b}, 32'd0);
    check({tag, "_it_a"}, {31'd0, int_timer_a}, 32'd0);
    check({tag, "_it_b"}, {31'd0, int_timer_b}, 32'd0);
  endtask

  task automatic do_reset(input int ncyc);
    chk_on = 1'b0;
    rst_n = 1'b0;
    expq.delete();
    model_reset();
    #1;
    check_outputs_zero("rst_async");
    repeat (ncyc) begin
      @(negedge clk);
      wr_en = 1'($urandom); wr_addr = 4'($urandom); wr_data = $urandom;
      irq_ack = 4'($urandom); rd_addr = 4'($urandom);
      @(posedge clk);
      #1;
      check_outputs_zero("rst_hold");
    end
    @(posedge clk);
    #2;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'd0; irq_ack = 4'd0; rd_addr = 4'd0;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, highs;
    rst_n = 1'b1;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'd0; irq_ack = 4'd0; rd_addr = 4'd0;
    #1;
    do_reset(6);
    for (int i = 0; i < 16; i++) step(1'b0, 4'd0, 32'd0, 4'd0, 4'(i));

    // Periodic ch0: LOAD=3 gives a 4-clock period on the PRE_DIV=1 build.
    wr(4'd1, 32'd3);
    wr(4'd0, 32'd5);
    wait_irq(0, 0, 20, n);
    check("a_first_period", 32'(n), 32'd4);
    for (int r = 0; r < 2; r++) begin
      ack_step(4'b0001);
      wait_irq(0, 0, 20, n);
      check("a_period", 32'(n + 1), 32'd4);
    end
    wr(4'd0, 32'd0);
    ack_step(4'b0001);

    // One-shot ch2: LOAD=5 expires after 6 ticks, then en self-clears.
    wr(4'd9, 32'd5);
    wr(4'd8, 32'd7);
    wait_irq(0, 2, 20, n);
    check("a_oneshot_delay", 32'(n), 32'd6);
    step(1'b0, 4'd0, 32'd0, 4'd0, 4'd8);
    check("a_oneshot_ctrl", rd_data_a, 32'd6);
    step(1'b0, 4'd0, 32'd0, 4'd0, 4'd10);
    check("a_oneshot_count", rd_data_a, 32'd0);
    ack_step(4'b0100);
    highs = 0;
    repeat (50) begin
      idle();
      if (irq_a[2]) highs++;
    end
    check("a_oneshot_no_refire", 32'(highs), 32'd0);

    // Clear race ch1: LOAD=0 periodic sets pending on every tick.
    wr(4'd5, 32'd0);
    wr(4'd4, 32'd5);
    idle();
    check("a_race_first", {31'd0, irq_a[1]}, 32'd1);
    for (int r = 0; r < 6; r++) begin
      ack_step(4'b0010);
      check("a_race_ack", {31'd0, irq_a[1]}, 32'd1);
      idle();
    end
    wr(4'd7, 32'd0);
    check("a_status_w0", {31'd0, irq_a[1]}, 32'd1);
    wr(4'd4, 32'd0);
    wr(4'd7, 32'd1);
    check("a_status_w1_clear", {31'd0, irq_a[1]}, 32'd0);

    // PRE_DIV=4 build ch0: LOAD=2 -> 12 clocks; LOAD=1 mid-count -> 8 clocks after next reload.
    wr(4'd0, 32'd0);
    wr(4'd3, 32'd1);
    wr(4'd1, 32'd2);
    wr(4'd0, 32'd5);
    wait_irq(1, 0, 30, n);
    check("b_first_seen", {31'd0, irq_b[0]}, 32'd1);
    ack_step(4'b0001);
    wait_irq(1, 0, 30, n);
    check("b_period_12", 32'(n + 1), 32'd12);
    ack_step(4'b0001);
    wr(4'd1, 32'd1);
    wait_irq(1, 0, 30, n);
    check("b_period_after_load_wr", 32'(n + 2), 32'd12);
    ack_step(4'b0001);
    wait_irq(1, 0, 30, n);
    check("b_period_8", 32'(n + 1), 32'd8);
    wr(4'd0, 32'd0);

    // Masking on ch3 of build A; ch3 is out of range on build B.
    wr(4'd13, 32'd2);
    wr(4'd12, 32'd1);
    repeat (10) begin
      idle();
      check("a_masked_irq", {31'd0, irq_a[3]}, 32'd0);
    end
    step(1'b0, 4'd0, 32'd0, 4'd0, 4'd15);
    check("a_masked_pending", rd_data_a, 32'd1);
    wr(4'd12, 32'd5);
    check("a_unmask_irq", {31'd0, irq_a[3]}, 32'd1);
    step(1'b0, 4'd0, 32'd0, 4'd0, 4'd13);
    check("a_ch3_load", rd_data_a, 32'd2);
    check("b_oor_read", rd_data_b, 32'd0);

    // Random traffic against the model.
    for (int r = 0; r < 2000; r++) begin
      bit [3:0]  a, ack;
      bit [31:0] d;
      a   = 4'($urandom_range(0, 15));
      d   = (a[1:0] == 2'd1) ? 32'($urandom_range(0, 7)) : $urandom;
      ack = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      step(($urandom_range(0, 9) < 3), a, d, ack, 4'($urandom_range(0, 15)));
    end

    // Mid-count reset, then nothing may resume counting.
    wr(4'd1, 32'd2);
    wr(4'd0, 32'd5);
    idle();
    do_reset(3);
    for (int r = 0; r < 60; r++) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
